// File: rtl/hex_display_scanner_if.sv
// Bus between the syscall decoder and the 8-digit seven-segment scanner:
// load/data/halt toward the display, drive signals back out to the board.
interface hex_display_scanner_if;
    logic        load;
    logic [31:0] data_in;
    logic        halt;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_start;

    modport master (
        output load, data_in, halt,
        input  an, seg, dp, pending, frame_start
    );

    modport slave (
        input  load, data_in, halt,
        output an, seg, dp, pending, frame_start
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 8-digit hex display driver with frame-aligned value commit,
// optional leading-zero blanking and a sticky halt indicator on digit 0's dp.
module hex_display_scanner #(
    parameter int CLK_DIV  = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_scanner_if.slave  bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [2:0]    digit;
    logic [31:0]   disp;
    logic [31:0]   pend;
    logic          halted;
    logic          tick;
    logic          commit;
    logic [31:0]   upper;
    logic          blank;
    logic [6:0]    seg_dec;

    assign tick   = (div_cnt == DW'(CLK_DIV - 1));
    assign commit = tick && (digit == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            digit   <= digit + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A load landing on the commit edge goes straight into disp so it is not
    // deferred by a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend             <= '0;
            disp             <= '0;
            bus.pending      <= 1'b0;
            bus.frame_start  <= 1'b0;
            halted           <= 1'b0;
        end else begin
            if (bus.load)
                pend <= bus.data_in;
            if (commit) begin
                bus.pending <= 1'b0;
                if (bus.load)
                    disp <= bus.data_in;
                else if (bus.pending)
                    disp <= pend;
            end else if (bus.load) begin
                bus.pending <= 1'b1;
            end
            bus.frame_start <= commit;
            if (bus.halt)
                halted <= 1'b1;
        end
    end

    // Digit i is a leading zero when every nibble from i upward is zero.
    assign upper = disp >> {digit, 2'b00};
    assign blank = (BLANK_LZ != 0) && (digit != 3'd0) && (upper == '0);

    always_comb begin
        seg_dec = 7'h7F;
        case (upper[3:0])
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an  <= '1;
            bus.seg <= '1;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= blank ? 8'hFF : ~(8'h01 << digit);
            bus.seg <= blank ? 7'h7F : seg_dec;
            bus.dp  <= !(halted && (digit == 3'd0));
        end
    end
endmodule
